// File: rtl/ws2812_rx_if.sv
// Decoded-word output bundle of the WS2812 receiver.
// master: the receiver driving words, frame markers and errors.
// slave : any consumer of that stream (loopback checker, pass-through logic).
//   rx_data    24  last complete word, bit 23 = first bit on the wire
//   rx_valid    1  one-cycle pulse, rx_data/rx_index updated this cycle
//   rx_index    6  LED position of rx_data within the frame
//   frame_done  1  one-cycle pulse when the latch gap ends a frame
//   frame_len   7  complete words in the last frame, held until the next frame_done
//   rx_err      1  one-cycle pulse on any protocol error
interface ws2812_rx_if;
    logic [23:0] rx_data;
    logic        rx_valid;
    logic [5:0]  rx_index;
    logic        frame_done;
    logic [6:0]  frame_len;
    logic        rx_err;

    modport master (
        output rx_data, rx_valid, rx_index, frame_done, frame_len, rx_err
    );

    modport slave (
        input  rx_data, rx_valid, rx_index, frame_done, frame_len, rx_err
    );
endinterface

// File: rtl/ws2812_rx.sv
// Purpose : decode a WS2812 NRZ stream into 24-bit words tagged with LED index; flag frame end on the latch gap.
// Latency : rx_valid 1 clock after the synchronised fall of a word's 24th bit (~3 clocks after the pin edge).
// Backpr. : none; the line cannot be stalled, so each output is a one-cycle pulse that must be taken when it fires.
// Ports   : sys_clk, sys_rst_n (synchronous, active low), din (asynchronous pin), rx (ws2812_rx_if.master).
module ws2812_rx #(
    parameter int BIT_THRESH = 28,   // high clocks >= this decode as 1
    parameter int HIGH_MIN   = 5,    // shorter high pulse is a glitch
    parameter int HIGH_MAX   = 60,   // longer high pulse is an error
    parameter int RESET_CYC  = 2500, // low clocks forming the latch gap
    parameter int MAX_LEDS   = 64    // words accepted per frame
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        din,
    ws2812_rx_if.master rx
);

    localparam int LW = $clog2(RESET_CYC + 1);
    localparam int HW = $clog2(HIGH_MAX + 2);

    localparam logic [LW-1:0] LOW_TC   = LW'(RESET_CYC);
    localparam logic [HW-1:0] HIGH_SAT = HW'(HIGH_MAX + 1);
    localparam logic [HW-1:0] HI_MIN   = HW'(HIGH_MIN);
    localparam logic [HW-1:0] HI_MAX   = HW'(HIGH_MAX);
    localparam logic [HW-1:0] HI_THR   = HW'(BIT_THRESH);
    localparam logic [6:0]    WORD_MAX = 7'(MAX_LEDS);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t        state_q;
    logic          din_meta_q, din_s_q, din_d_q;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [HW-1:0] high_cnt_q, high_cnt_d;
    logic [4:0]    bit_cnt_q;
    logic [6:0]    word_cnt_q;
    logic [22:0]   shift_q;
    logic [23:0]   shift_nx;
    logic          rise, fall, low_tc, bit_val;

    logic [23:0]   rx_data_q;
    logic [5:0]    rx_index_q;
    logic [6:0]    frame_len_q;
    logic          rx_valid_q, frame_done_q, rx_err_q;

    always_comb begin
        rise = din_s_q & ~din_d_q;
        fall = ~din_s_q & din_d_q;

        // Counters saturate so long idle or stuck-high lines never wrap back
        // into a valid-looking count.
        if (din_s_q)                  low_cnt_d = '0;
        else if (low_cnt_q == LOW_TC) low_cnt_d = low_cnt_q;
        else                          low_cnt_d = low_cnt_q + LW'(1);

        if (!din_s_q)                    high_cnt_d = '0;
        else if (high_cnt_q == HIGH_SAT) high_cnt_d = high_cnt_q;
        else                             high_cnt_d = high_cnt_q + HW'(1);

        // Terminal count includes the current low cycle, so an exactly
        // RESET_CYC-long gap is recognised before the next rise arrives.
        low_tc = (low_cnt_d == LOW_TC);

        // On the fall cycle high_cnt_q holds the full high time of the pulse.
        bit_val  = (high_cnt_q >= HI_THR);
        shift_nx = {shift_q, bit_val};
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= SYNC;
            din_meta_q   <= 1'b0;
            din_s_q      <= 1'b0;
            din_d_q      <= 1'b0;
            low_cnt_q    <= '0;
            high_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_index_q   <= '0;
            frame_len_q  <= '0;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            din_meta_q   <= din;
            din_s_q      <= din_meta_q;
            din_d_q      <= din_s_q;
            low_cnt_q    <= low_cnt_d;
            high_cnt_q   <= high_cnt_d;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rx_err_q     <= 1'b0;

            case (state_q)
                SYNC: begin
                    if (low_tc) state_q <= IDLE;
                end
                IDLE: begin
                    if (rise) begin
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        state_q    <= HIGH;
                    end
                end
                HIGH: begin
                    if (high_cnt_q > HI_MAX) begin
                        rx_err_q <= 1'b1;
                        state_q  <= SYNC;
                    end else if (fall) begin
                        if (high_cnt_q < HI_MIN) begin
                            rx_err_q <= 1'b1;
                            state_q  <= SYNC;
                        end else begin
                            shift_q <= shift_nx[22:0];
                            state_q <= LOW;
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q <= '0;
                                if (word_cnt_q < WORD_MAX) begin
                                    rx_data_q  <= shift_nx;
                                    rx_index_q <= word_cnt_q[5:0];
                                    rx_valid_q <= 1'b1;
                                    word_cnt_q <= word_cnt_q + 7'd1;
                                end else begin
                                    // Frame overflow: drop the word, keep decoding.
                                    rx_err_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_q <= HIGH;
                    end else if (low_tc) begin
                        frame_done_q <= 1'b1;
                        frame_len_q  <= word_cnt_q;
                        // A partial word at the gap is discarded and flagged.
                        if (bit_cnt_q != '0) rx_err_q <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign rx.rx_data    = rx_data_q;
    assign rx.rx_valid   = rx_valid_q;
    assign rx.rx_index   = rx_index_q;
    assign rx.frame_done = frame_done_q;
    assign rx.frame_len  = frame_len_q;
    assign rx.rx_err     = rx_err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Purpose : exercise ws2812_rx with directed and random pulse trains against a pulse-level reference model.
// Latency : model is untimed except for the rx_valid latency from the pin's falling edge.
// Backpr. : none; every DUT pulse is captured by a free-running monitor.
module tb_ws2812_rx;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic din;

    always #10 sys_clk = ~sys_clk;

    ws2812_rx_if rx_if ();

    ws2812_rx dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (din),
        .rx        (rx_if)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: operates on whole pulses (level + duration in clocks).
    bit          m_synced, m_in_frame;
    int          m_bits, m_words;
    logic [23:0] m_shift;
    logic [23:0] exp_data[$], act_data[$];
    logic [5:0]  exp_idx[$],  act_idx[$];
    int          exp_len[$],  act_len[$];
    int          exp_err, act_err, exp_efd, act_efd;
    int          exp_last_len;
    int          last_fall_cyc, last_valid_cyc;

    task automatic model_reset();
        m_synced     = 1'b0;
        m_in_frame   = 1'b0;
        m_bits       = 0;
        m_words      = 0;
        m_shift      = '0;
        exp_last_len = 0;
    endtask

    task automatic model_high(int n);
        if (!m_synced) return;
        if (n < 5 || n > 60) begin
            exp_err++;
            m_synced   = 1'b0;
            m_in_frame = 1'b0;
            m_bits     = 0;
            m_words    = 0;
            return;
        end
        m_in_frame = 1'b1;
        m_shift    = {m_shift[22:0], (n >= 28)};
        m_bits++;
        if (m_bits == 24) begin
            m_bits = 0;
            if (m_words < 64) begin
                exp_data.push_back(m_shift);
                exp_idx.push_back(6'(m_words));
                m_words++;
            end else begin
                exp_err++;
            end
        end
    endtask

    task automatic model_low(int n);
        if (n < 2500) return;
        if (!m_synced) begin
            m_synced = 1'b1;
        end else if (m_in_frame) begin
            exp_len.push_back(m_words);
            if (m_bits != 0) begin
                exp_err++;
                exp_efd++;
            end
            m_in_frame = 1'b0;
            m_bits     = 0;
            m_words    = 0;
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_if.rx_valid) begin
                act_data.push_back(rx_if.rx_data);
                act_idx.push_back(rx_if.rx_index);
                last_valid_cyc = cyc;
            end
            if (rx_if.frame_done) act_len.push_back(int'(rx_if.frame_len));
            if (rx_if.rx_err) act_err++;
            if (rx_if.rx_err && rx_if.frame_done) act_efd++;
        end
    end

    task automatic seg(bit lvl, int n);
        if (lvl) model_high(n);
        else     model_low(n);
        din = lvl;
        repeat (n) @(negedge sys_clk);
    endtask

    // mode 0 nominal, 1 random legal, 2 threshold edge, 3 fast, 4 min/max high
    task automatic send_bit(bit b, int mode, int lo_ovr);
        int hi, lo;
        case (mode)
            0:       begin hi = b ? 35 : 17; lo = b ? 27 : 45; end
            1:       begin
                         hi = b ? int'($urandom_range(60, 28)) : int'($urandom_range(27, 5));
                         lo = int'($urandom_range(20, 1));
                     end
            2:       begin hi = b ? 28 : 27; lo = 20; end
            3:       begin hi = b ? 28 : 5;  lo = 1;  end
            default: begin hi = b ? 60 : 5;  lo = 10; end
        endcase
        if (lo_ovr > 0) lo = lo_ovr;
        seg(1'b1, hi);
        last_fall_cyc = cyc;
        seg(1'b0, lo);
    endtask

    task automatic send_word(logic [23:0] w, int mode, int last_lo);
        for (int i = 23; i >= 0; i--) send_bit(w[i], mode, (i == 0) ? last_lo : 0);
    endtask

    task automatic check_sb(string tag);
        repeat (4) @(negedge sys_clk);
        chk({tag, "/n_valid"}, act_data.size(), exp_data.size());
        while (exp_data.size() > 0 && act_data.size() > 0) begin
            chk({tag, "/rx_data"},  act_data.pop_front(), exp_data.pop_front());
            chk({tag, "/rx_index"}, act_idx.pop_front(),  exp_idx.pop_front());
        end
        chk({tag, "/n_frames"}, act_len.size(), exp_len.size());
        if (exp_len.size() > 0) exp_last_len = exp_len[$];
        while (exp_len.size() > 0 && act_len.size() > 0)
            chk({tag, "/frame_len"}, act_len.pop_front(), exp_len.pop_front());
        chk({tag, "/n_err"},       act_err, exp_err);
        chk({tag, "/err_with_fd"}, act_efd, exp_efd);
        chk({tag, "/frame_len_hold"}, rx_if.frame_len, exp_last_len);
        exp_data.delete(); act_data.delete();
        exp_idx.delete();  act_idx.delete();
        exp_len.delete();  act_len.delete();
        exp_err = 0; act_err = 0; exp_efd = 0; act_efd = 0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "/rx_data"},    rx_if.rx_data,    0);
        chk({tag, "/rx_valid"},   rx_if.rx_valid,   0);
        chk({tag, "/rx_index"},   rx_if.rx_index,   0);
        chk({tag, "/frame_done"}, rx_if.frame_done, 0);
        chk({tag, "/frame_len"},  rx_if.frame_len,  0);
        chk({tag, "/rx_err"},     rx_if.rx_err,     0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_err = 0; act_err = 0; exp_efd = 0; act_efd = 0;
        last_fall_cyc = 0; last_valid_cyc = 0;
        sys_rst_n = 1'b0;
        din       = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        chk_zero("reset");
        sys_rst_n = 1'b1;

        // Single word framed by gaps, plus pin-to-rx_valid latency.
        seg(1'b0, 3000);
        send_word(24'hFF0000, 0, 0);
        seg(1'b0, 3000);
        check_sb("t1");
        chk("t1/latency", last_valid_cyc - last_fall_cyc, 3);
        chk("t1/data_hold", rx_if.rx_data, 24'hFF0000);

        // Full frame of 64 words, then one word too many.
        for (int i = 0; i < 64; i++) send_word(24'(i), 3, 0);
        seg(1'b0, 2520);
        check_sb("t2_64");
        for (int i = 0; i < 65; i++) send_word(24'(i), 3, 0);
        seg(1'b0, 2520);
        check_sb("t2_65");

        // Partial word at the gap.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(1, 0)), 0, 0);
        seg(1'b0, 2520);
        check_sb("t3");

        // Decode threshold and high-time limits.
        send_word(24'h555555, 2, 0);
        send_word(24'($urandom()), 4, 0);
        seg(1'b0, 2520);
        check_sb("t4_edge");
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 0);
            seg(1'b1, (k == 0) ? 4 : 61);
            seg(1'b0, 30);
            send_word(24'($urandom()), 0, 0);
            seg(1'b0, 2520);
            check_sb((k == 0) ? "t4_short" : "t4_long");
        end

        // Reset mid-frame.
        for (int i = 0; i < 5; i++) send_word(24'($urandom()), 3, (i == 4) ? 20 : 0);
        check_sb("t5_pre");
        sys_rst_n = 1'b0;
        model_reset();
        @(negedge sys_clk);
        chk_zero("t5_rst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send_word(24'($urandom()), 3, 0);
        seg(1'b0, 2520);
        send_word(24'h123456, 3, 0);
        send_word(24'hABCDEF, 3, 0);
        seg(1'b0, 2520);
        check_sb("t5_post");

        // Gap exactly at and one below the latch threshold.
        send_word(24'($urandom()), 3, 0);
        send_word(24'($urandom()), 3, 2500);
        send_word(24'($urandom()), 3, 0);
        seg(1'b0, 2520);
        check_sb("t6_2500");
        send_word(24'($urandom()), 3, 0);
        send_word(24'($urandom()), 3, 2499);
        send_word(24'($urandom()), 3, 0);
        send_word(24'($urandom()), 3, 0);
        seg(1'b0, 2520);
        check_sb("t6_2499");

        // Random frames with occasional partial words and bad pulses.
        for (int f = 0; f < 3; f++) begin
            int nw, r;
            nw = int'($urandom_range(2, 0));
            for (int w = 0; w < nw; w++) send_word(24'($urandom()), 1, 0);
            r = int'($urandom_range(3, 0));
            if (r == 1) begin
                int nb;
                nb = int'($urandom_range(23, 1));
                for (int b = 0; b < nb; b++) send_bit(1'($urandom_range(1, 0)), 1, 0);
            end else if (r == 2) begin
                seg(1'b1, ($urandom_range(1, 0) == 1) ? int'($urandom_range(4, 1))
                                                       : int'($urandom_range(90, 61)));
                seg(1'b0, 10);
            end
            seg(1'b0, int'($urandom_range(2520, 2500)));
            check_sb("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
